// File: rtl/instr_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder_if
// Brief    : CPU fetch/write bus plus program-load stream for the responder.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_mem_responder_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] instruction_fetch;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              ld_start;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              ld_ready;
   logic              cpu_run;
   logic [ADDR_W:0]   ld_count;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, ld_start, ld_valid, ld_data, ld_last,
      input  instruction_fetch, ld_ready, cpu_run, ld_count
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, ld_start, ld_valid, ld_data, ld_last,
      output instruction_fetch, ld_ready, cpu_run, ld_count
   );
endinterface
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder
// Brief    : Instruction/data store with program-load FSM and 1-cycle fetch.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_responder #(
   parameter int              ADDR_W    = 11,
   parameter int              DATA_W    = 32,
   parameter int              DEPTH     = 2**ADDR_W,
   parameter logic [DATA_W-1:0] NOOP_WORD = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   instr_mem_responder_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_ld_ptr;
   logic [ADDR_W:0]     r_ld_count;
   logic                r_ld_ready;
   logic                r_cpu_run;
   logic [DATA_W-1:0]   r_fetch;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_ld_accept;
   logic                w_ld_final;
   logic                w_cpu_write;
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_data;

   assign w_ld_accept = r_ld_ready && bus.ld_valid;
   assign w_ld_final  = w_ld_accept && (bus.ld_last || (r_ld_ptr == LAST_PTR));
   assign w_cpu_write = (r_state == RUN) && bus.wr_en;

   // Load port and CPU port are mutually exclusive by state, so one write port suffices.
   always_comb begin
      w_mem_we   = 1'b0;
      w_mem_addr = bus.wr_addr;
      w_mem_data = bus.wr_data;
      if (w_ld_accept) begin
         w_mem_we   = 1'b1;
         w_mem_addr = r_ld_ptr;
         w_mem_data = bus.ld_data;
      end else if (w_cpu_write) begin
         w_mem_we   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_data;
      end
   end

   // Non-blocking read alongside the write gives read-first behaviour.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch <= NOOP_WORD;
      end else if (r_state == RUN) begin
         r_fetch <= r_mem[bus.rd_addr];
      end else begin
         r_fetch <= NOOP_WORD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_ld_ready <= 1'b0;
         r_cpu_run  <= 1'b0;
         r_ld_ptr   <= '0;
         r_ld_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.ld_start) begin
                  r_state    <= LOAD;
                  r_ld_ready <= 1'b1;
                  r_ld_ptr   <= '0;
                  r_ld_count <= '0;
               end
            end
            LOAD: begin
               if (w_ld_accept) begin
                  r_ld_ptr <= r_ld_ptr + 1'b1;
                  if (r_ld_count != FULL_COUNT) begin
                     r_ld_count <= r_ld_count + 1'b1;
                  end
                  if (w_ld_final) begin
                     r_state    <= RUN;
                     r_ld_ready <= 1'b0;
                     r_cpu_run  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (bus.ld_start) begin
                  r_state    <= LOAD;
                  r_ld_ready <= 1'b1;
                  r_cpu_run  <= 1'b0;
                  r_ld_ptr   <= '0;
                  r_ld_count <= '0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_ld_ready <= 1'b0;
               r_cpu_run  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.instruction_fetch = r_fetch;
   assign bus.ld_ready          = r_ld_ready;
   assign bus.cpu_run           = r_cpu_run;
   assign bus.ld_count          = r_ld_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_responder
// Brief    : Self-checking bench: vector table, directed sequences, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_responder;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2048;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   instr_mem_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NOOP_WORD(32'h0000_0000)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a plain word array plus "loading"/"running" flags.
   logic [31:0] m_mem   [DEPTH];
   bit          m_known [DEPTH];
   bit          m_loading, m_running;
   int          m_count;
   logic [31:0] m_fetch;
   bit          m_fetch_known;

   typedef struct {
      logic        start, valid;
      logic [31:0] data;
      logic        last, wen;
      logic [10:0] waddr;
      logic [31:0] wdata;
      logic [10:0] raddr;
      logic [31:0] exp_fetch;
      logic        exp_ready, exp_run;
      int          exp_count;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic start, input logic valid, input logic [31:0] data,
                        input logic last, input logic wen, input logic [10:0] waddr,
                        input logic [31:0] wdata, input logic [10:0] raddr);
      bus.ld_start = start;
      bus.ld_valid = valid;
      bus.ld_data  = data;
      bus.ld_last  = last;
      bus.wr_en    = wen;
      bus.wr_addr  = waddr;
      bus.wr_data  = wdata;
      bus.rd_addr  = raddr;
   endtask

   task automatic idle_inputs(input logic [10:0] raddr);
      drive(1'b0, 1'b0, $urandom, 1'b0, 1'b0, 11'($urandom), $urandom, raddr);
   endtask

   task automatic model_reset();
      m_loading     = 1'b0;
      m_running     = 1'b0;
      m_count       = 0;
      m_fetch       = 32'h0;
      m_fetch_known = 1'b1;
   endtask

   // One clock edge of the specified behaviour, using the inputs currently driven.
   task automatic model_edge();
      m_fetch       = 32'h0;
      m_fetch_known = 1'b1;
      if (m_running) begin
         m_fetch       = m_mem[bus.rd_addr];
         m_fetch_known = m_known[bus.rd_addr];
         if (bus.wr_en) begin
            m_mem[bus.wr_addr]   = bus.wr_data;
            m_known[bus.wr_addr] = 1'b1;
         end
      end
      if (m_loading) begin
         if (bus.ld_valid) begin
            m_mem[m_count]   = bus.ld_data;
            m_known[m_count] = 1'b1;
            m_count++;
            if (bus.ld_last || m_count == DEPTH) begin
               m_loading = 1'b0;
               m_running = 1'b1;
            end
         end
      end else if (bus.ld_start) begin
         m_loading = 1'b1;
         m_running = 1'b0;
         m_count   = 0;
      end
   endtask

   task automatic compare_model();
      check("ld_ready", 32'(bus.ld_ready), 32'(m_loading));
      check("cpu_run",  32'(bus.cpu_run),  32'(m_running));
      check("ld_count", 32'(bus.ld_count), 32'(m_count));
      if (m_fetch_known) check("fetch", bus.instruction_fetch, m_fetch);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   // Reset asserted away from the clock edge; outputs must clear without a clock.
   task automatic async_reset();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_run",   32'(bus.cpu_run),  32'h0);
      check("rst_ready", 32'(bus.ld_ready), 32'h0);
      check("rst_count", 32'(bus.ld_count), 32'h0);
      check("rst_fetch", bus.instruction_fetch, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      step();
   endtask

   initial begin
      logic [31:0] d1, d2, d3, w0, w1;

      vecs[0]  = '{1,0,32'h0,0, 0,11'h0,32'h0, 11'h0, 32'h0,        1,0,0};
      vecs[1]  = '{0,1,32'hA0000001,0, 0,11'h0,32'h0, 11'h0, 32'h0, 1,0,1};
      vecs[2]  = '{0,1,32'hA0000002,0, 0,11'h0,32'h0, 11'h0, 32'h0, 1,0,2};
      vecs[3]  = '{0,1,32'hA0000003,0, 0,11'h0,32'h0, 11'h0, 32'h0, 1,0,3};
      vecs[4]  = '{0,1,32'hA0000004,1, 0,11'h0,32'h0, 11'h0, 32'h0, 0,1,4};
      vecs[5]  = '{0,0,32'h0,0, 0,11'h0,32'h0, 11'h2, 32'hA0000003,  0,1,4};
      vecs[6]  = '{0,0,32'h0,0, 0,11'h0,32'h0, 11'h0, 32'hA0000001,  0,1,4};
      vecs[7]  = '{0,0,32'h0,0, 1,11'h5,32'h12345678, 11'h0, 32'hA0000001, 0,1,4};
      vecs[8]  = '{0,0,32'h0,0, 1,11'h5,32'hDEADBEEF, 11'h5, 32'h12345678, 0,1,4};
      vecs[9]  = '{0,0,32'h0,0, 0,11'h0,32'h0, 11'h5, 32'hDEADBEEF,  0,1,4};
      vecs[10] = '{1,0,32'h0,0, 0,11'h0,32'h0, 11'h5, 32'hDEADBEEF,  1,0,0};
      vecs[11] = '{0,0,32'h0,0, 1,11'h5,32'hBAD0BAD0, 11'h5, 32'h0,  1,0,0};
      vecs[12] = '{0,1,32'hC0000000,1, 0,11'h0,32'h0, 11'h5, 32'h0,  0,1,1};
      vecs[13] = '{0,0,32'h0,0, 0,11'h0,32'h0, 11'h5, 32'hDEADBEEF,  0,1,1};
      vecs[14] = '{0,0,32'h0,0, 0,11'h0,32'h0, 11'h0, 32'hC0000000,  0,1,1};

      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
      model_reset();
      reset = 1'b1;
      idle_inputs(11'h0);
      repeat (2) @(posedge clk);
      #1;
      compare_model();
      @(negedge clk);
      reset = 1'b0;

      // Idle after reset: nothing moves without ld_start.
      for (int i = 0; i < 5; i++) begin
         idle_inputs(11'($urandom));
         step();
      end

      // Basic load, fetch, read-first write, and writes blocked during LOAD.
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].start, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].wen,
               vecs[i].waddr, vecs[i].wdata, vecs[i].raddr);
         step();
         check($sformatf("vec%0d_ready", i), 32'(bus.ld_ready), 32'(vecs[i].exp_ready));
         check($sformatf("vec%0d_run", i),   32'(bus.cpu_run),  32'(vecs[i].exp_run));
         check($sformatf("vec%0d_count", i), 32'(bus.ld_count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d_fetch", i), bus.instruction_fetch, vecs[i].exp_fetch);
      end

      // Load with valid gaps; ld_last on an invalid cycle must not end the load.
      d1 = 32'h11110001; d2 = 32'h22220002; d3 = 32'h33330003;
      drive(1, 0, 32'h0, 0, 0, 11'h0, 32'h0, 11'h0); step();
      drive(0, 1, d1, 0, 0, 11'h0, 32'h0, 11'h0);    step();
      drive(0, 0, 32'hFFFF0000, 1, 0, 11'h0, 32'h0, 11'h0); step();
      drive(0, 0, 32'hFFFF0001, 0, 0, 11'h0, 32'h0, 11'h0); step();
      check("gap_ready", 32'(bus.ld_ready), 32'h1);
      drive(0, 1, d2, 0, 0, 11'h0, 32'h0, 11'h0);    step();
      drive(0, 1, d3, 1, 0, 11'h0, 32'h0, 11'h0);    step();
      check("gap_count", 32'(bus.ld_count), 32'h3);
      check("gap_run",   32'(bus.cpu_run),  32'h1);
      idle_inputs(11'h1); step();
      check("gap_mem1", bus.instruction_fetch, d2);

      // Full-depth stream without ld_last; a mid-load ld_start is ignored.
      drive(1, 0, 32'h0, 0, 0, 11'h0, 32'h0, 11'h0); step();
      for (int i = 0; i < DEPTH; i++) begin
         drive((i == 100), 1, $urandom, 0, 1, 11'($urandom), $urandom, 11'h0);
         step();
         if (i == DEPTH - 2) check("full_ready_before_end", 32'(bus.ld_ready), 32'h1);
      end
      check("full_count", 32'(bus.ld_count), 32'(DEPTH));
      check("full_run",   32'(bus.cpu_run),  32'h1);
      check("full_ready", 32'(bus.ld_ready), 32'h0);
      idle_inputs(11'h7); step();

      // Reload from RUN, abort with reset after two beats; those words survive.
      w0 = 32'h5A5A0000; w1 = 32'h5A5A0001;
      drive(1, 0, 32'h0, 0, 0, 11'h0, 32'h0, 11'h0); step();
      check("reload_run", 32'(bus.cpu_run), 32'h0);
      drive(0, 1, w0, 0, 0, 11'h0, 32'h0, 11'h0); step();
      drive(0, 1, w1, 0, 0, 11'h0, 32'h0, 11'h0); step();
      idle_inputs(11'h0);
      async_reset();
      idle_inputs(11'h0); step();
      check("post_rst_count", 32'(bus.ld_count), 32'h0);
      check("post_rst_run",   32'(bus.cpu_run),  32'h0);
      drive(1, 0, 32'h0, 0, 0, 11'h0, 32'h0, 11'h0); step();
      drive(0, 1, 32'h77770000, 1, 0, 11'h0, 32'h0, 11'h0); step();
      idle_inputs(11'h1); step();
      check("kept_word1", bus.instruction_fetch, w1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(39) == 0), ($urandom_range(9) < 7), $urandom,
               ($urandom_range(49) == 0), ($urandom_range(2) == 0),
               11'($urandom), $urandom, 11'($urandom));
         if ($urandom_range(599) == 0) async_reset();
         else step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
